wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

- Writeback-side initiator for the 32×32 register file's single write port (`RegWrite`/`RDaddr`/`RDdata`).
- Merges two result producers onto that port:
  - the single-cycle ALU pipeline, which cannot be back-pressured and always has priority;
  - the load/multi-cycle unit, which uses a valid/ready handshake and is buffered in a small FIFO.
- Preserves per-register write ordering and exports a pending-write bitmap to the hazard unit.
- Includes a starvation guard so buffered results cannot wait forever behind back-to-back ALU writes.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 5, register address width.
- `DEPTH`, 4, LSU FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 3, cycles the FIFO head may wait before an ALU stall is requested (≥1).

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `alu_valid_i`  in  1  ALU result valid this cycle.
- `alu_addr_i`  in  ADDR_W  ALU destination register.
- `alu_data_i`  in  DATA_W  ALU result.
- `alu_stall_o`  out  1  registered request: upstream must hold `alu_valid_i` low.
- `lsu_valid_i`  in  1  LSU result offered.
- `lsu_ready_o`  out  1  FIFO can accept.
- `lsu_addr_i`  in  ADDR_W  LSU destination register.
- `lsu_data_i`  in  DATA_W  LSU result.
- `RegWrite_o`  out  1  register-file write enable, registered.
- `RDaddr_o`  out  ADDR_W  write address, registered.
- `RDdata_o`  out  DATA_W  write data, registered.
- `pend_o`  out  2^ADDR_W  bit r set while a live buffered LSU write targets register r.
- `fifo_cnt_o`  out  clog2(DEPTH)+1  occupancy, including killed entries.

## Operation
Handshake and FIFO:
- LSU transfer occurs when `lsu_valid_i && lsu_ready_o`.
- `lsu_ready_o = rst_i && (count < DEPTH)`, based only on registered count; no same-cycle pop credit.
- Each FIFO entry holds {live, addr, data}.
- Pushes write live=1, except addr 0, which is pushed with live=0.

Per-cycle arbitration (priority order):
1. `alu_stall_o==1` and FIFO nonempty: pop head; if live, issue it.
2. `alu_valid_i`: issue the ALU write; addr 0 issues `RegWrite_o=0`.
3. FIFO nonempty: pop head; issue it only if live.
4. Otherwise: `RegWrite_o=0`.

Ordering rule:
- An issued ALU write to address A clears `live` on every stored entry with addr A.
- An LSU entry pushed in the same cycle with addr A is younger and stays live.
- A killed entry still pops in its turn, consumes the port slot, and produces no write.

`alu_valid_i` while `alu_stall_o==1` is a protocol violation:
- The stall pop still wins; the ALU write is dropped.
- Sticky `err` flag, visible to the bench hierarchically only.

Starvation counter `age`:
- Resets to 0 on any pop or when the FIFO is empty.
- Otherwise increments, saturating at STARVE_MAX.
- `alu_stall_o` registers (`age==STARVE_MAX`) and falls the cycle after the head pops.

Other outputs:
- `pend_o` is the OR over live entries of onehot(addr); combinational from FIFO state.

Reset (`rst_i` low, asynchronous):
- FIFO empty, `age` and `err` cleared.
- All outputs 0: `RegWrite_o`, `RDaddr_o`, `RDdata_o`, `pend_o`, `fifo_cnt_o`, `alu_stall_o`, `lsu_ready_o`.
- Reset mid-operation discards buffered entries without writing them.

## Timing
- Write latency: input or pop in cycle N → `RegWrite_o`/`RDaddr_o`/`RDdata_o` valid in cycle N+1, held for exactly one cycle.
- A push in cycle N is poppable in N+1 at the earliest; minimum LSU latency is 2 cycles.
- Push and pop in the same cycle: count unchanged; wrap-around of head and tail pointers is modulo DEPTH.
- Full FIFO with a simultaneous pop: `lsu_ready_o` stays 0 that cycle and rises the next.
- Stall latency: the head waits STARVE_MAX cycles, `alu_stall_o` rises the next cycle, and the pop happens that same cycle.
- Consequence: worst-case head wait is STARVE_MAX+1 cycles.
- `lsu_ready_o` is the only output that depends combinationally on `rst_i`.

## Structure
- Shared package `wb_pkg`:
  - entry typedef {live, addr, data};
  - `DATA_W`/`ADDR_W` defaults;
  - the register-0 constant.
- Sub-module `wb_fifo`: circular buffer with count, plus a parallel per-entry address-compare kill port and a live-entry bitmap output.
- Top level holds the arbiter, the starvation counter and the output registers.

## Test plan
- Reset: assert `rst_i=0` mid-stream with 2 entries queued → all outputs 0 immediately; after release, `lsu_ready_o=1` and no stale write appears.
- ALU only: ALU writes `r5=0x11` → cycle N+1 shows `RegWrite_o=1`, `RDaddr_o=5`, `RDdata_o=0x11`.
- ALU addr 0: ALU writes `r0=0xFF` → `RegWrite_o=0`.
- Ordering kill: push LSU `r7=0xAA`, then ALU `r7=0xBB` one cycle later → final `r7=0xBB`; the `0xAA` slot pops with no write; `pend_o[7]` falls after the ALU write.
- Full FIFO: push 4 entries with ALU valid every cycle → `lsu_ready_o=0` and `fifo_cnt_o=4`.
- Starvation (same setup, `STARVE_MAX=3`): `alu_stall_o` rises after 3 waiting cycles; with ALU honouring it, one entry pops per stall cycle.
- Same-cycle same-address: ALU `r9=1` and LSU push `r9=2` in one cycle → ALU write issues; the LSU entry stays live and later writes 2; `pend_o[9]=1` until then.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback arbiter slice.
//   WB_DATA_W  : default register data width
//   WB_ADDR_W  : default register address width
//   REG_ZERO   : hardwired-zero register; writes to it never reach the file
//   wb_entry_t : one buffered LSU result {live, addr, data}
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                 live;
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular buffer of pending LSU results for the writeback arbiter.
// Besides push/pop it offers a kill port that clears the live bit of every
// stored entry whose address matches, and a bitmap of live destinations.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_push, i_pushAddr/Data : enqueue one entry (caller guarantees not full)
//   i_pop                   : dequeue head (caller guarantees not empty)
//   i_kill, i_killAddr      : clear live on stored entries targeting i_killAddr
//   o_headLive/Addr/Data    : current head entry
//   o_count                 : occupancy, killed entries included
//   o_liveMap               : bit r set while a live entry targets register r
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [ADDR_W-1:0]        i_pushAddr,
   input  logic [DATA_W-1:0]        i_pushData,
   input  logic                     i_pop,
   input  logic                     i_kill,
   input  logic [ADDR_W-1:0]        i_killAddr,
   output logic                     o_headLive,
   output logic [ADDR_W-1:0]        o_headAddr,
   output logic [DATA_W-1:0]        o_headData,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [(2**ADDR_W)-1:0]   o_liveMap
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]  r_live;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   // Storage and pointers. Popped slots drop their live bit so the bitmap
   // never sees stale entries. The push is written last so a same-cycle
   // push to a killed address stays live: it is younger than the kill.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_live  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && (r_addr[i] == i_killAddr)) begin
               r_live[i] <= 1'b0;
            end
         end
         if (i_pop) begin
            r_live[r_head] <= 1'b0;
            r_head         <= PTR_W'(r_head + 1'b1);
         end
         if (i_push) begin
            r_live[r_tail] <= (i_pushAddr != ADDR_W'(REG_ZERO));
            r_addr[r_tail] <= i_pushAddr;
            r_data[r_tail] <= i_pushData;
            r_tail         <= PTR_W'(r_tail + 1'b1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Destination bitmap of every live buffered write, for the hazard unit.
   always_comb begin
      o_liveMap = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_live[i]) begin
            o_liveMap[r_addr[i]] = 1'b1;
         end
      end
   end

   assign o_headLive = r_live[r_head];
   assign o_headAddr = r_addr[r_head];
   assign o_headData = r_data[r_head];
   assign o_count    = r_count;

endmodule

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
// Drives the register file's single write port from two producers: the
// ALU pipeline (no back-pressure, normally wins) and the LSU (valid/ready,
// buffered in wb_fifo). A starvation counter requests an ALU stall so the
// buffered head cannot wait forever.
//   clk_i, rst_i                        : clock, async active-low reset
//   alu_valid_i/addr_i/data_i           : ALU result this cycle
//   alu_stall_o                         : upstream must hold alu_valid_i low
//   lsu_valid_i/addr_i/data_i, lsu_ready_o : LSU handshake
//   RegWrite_o, RDaddr_o, RDdata_o      : registered write port
//   pend_o                              : live buffered destinations
//   fifo_cnt_o                          : FIFO occupancy
// ---------------------------------------------------------------------------
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int ADDR_W     = WB_ADDR_W,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     alu_valid_i,
   input  logic [ADDR_W-1:0]        alu_addr_i,
   input  logic [DATA_W-1:0]        alu_data_i,
   output logic                     alu_stall_o,
   input  logic                     lsu_valid_i,
   output logic                     lsu_ready_o,
   input  logic [ADDR_W-1:0]        lsu_addr_i,
   input  logic [DATA_W-1:0]        lsu_data_i,
   output logic                     RegWrite_o,
   output logic [ADDR_W-1:0]        RDaddr_o,
   output logic [DATA_W-1:0]        RDdata_o,
   output logic [(2**ADDR_W)-1:0]   pend_o,
   output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AGE_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_kill;
   logic              w_issue;
   logic [ADDR_W-1:0] w_selAddr;
   logic [DATA_W-1:0] w_selData;
   logic              w_headLive;
   logic [ADDR_W-1:0] w_headAddr;
   logic [DATA_W-1:0] w_headData;

   logic [AGE_W-1:0]  r_age;
   logic              r_stall;
   logic              r_err;

   // Readiness looks only at the registered count, never at a same-cycle pop.
   assign w_empty     = (w_count == '0);
   assign w_ready     = rst_i && (w_count < CNT_W'(DEPTH));
   assign w_push      = lsu_valid_i && w_ready;
   assign lsu_ready_o = w_ready;

   wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk      (clk_i),
      .i_rst_n    (rst_i),
      .i_push     (w_push),
      .i_pushAddr (lsu_addr_i),
      .i_pushData (lsu_data_i),
      .i_pop      (w_pop),
      .i_kill     (w_kill),
      .i_killAddr (alu_addr_i),
      .o_headLive (w_headLive),
      .o_headAddr (w_headAddr),
      .o_headData (w_headData),
      .o_count    (w_count),
      .o_liveMap  (pend_o)
   );

   // Port arbitration: an overdue FIFO head beats everything, then the ALU,
   // then the FIFO in idle slots. An ALU write kills older buffered writes
   // to the same register so they cannot overwrite it later. Killed heads
   // still pop and burn their slot without asserting the write enable.
   always_comb begin
      w_pop     = 1'b0;
      w_kill    = 1'b0;
      w_issue   = 1'b0;
      w_selAddr = '0;
      w_selData = '0;
      if (r_stall && !w_empty) begin
         w_pop     = 1'b1;
         w_issue   = w_headLive;
         w_selAddr = w_headAddr;
         w_selData = w_headData;
      end else if (alu_valid_i) begin
         w_kill    = 1'b1;
         w_issue   = (alu_addr_i != ADDR_W'(REG_ZERO));
         w_selAddr = alu_addr_i;
         w_selData = alu_data_i;
      end else if (!w_empty) begin
         w_pop     = 1'b1;
         w_issue   = w_headLive;
         w_selAddr = w_headAddr;
         w_selData = w_headData;
      end
   end

   // Output port registers plus the starvation counter. The age counts
   // cycles the current head has waited; the stall request registers a
   // saturated age and drops as soon as the head has been popped. The
   // error flag latches any ALU write offered while the stall was up.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         RegWrite_o <= 1'b0;
         RDaddr_o   <= '0;
         RDdata_o   <= '0;
         r_age      <= '0;
         r_stall    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         RegWrite_o <= w_issue;
         RDaddr_o   <= w_selAddr;
         RDdata_o   <= w_selData;
         if (w_pop || w_empty) begin
            r_age <= '0;
         end else if (r_age != AGE_W'(STARVE_MAX)) begin
            r_age <= r_age + 1'b1;
         end
         r_stall <= (r_age == AGE_W'(STARVE_MAX)) && !w_pop;
         r_err   <= r_err | (alu_valid_i & r_stall);
      end
   end

   assign alu_stall_o = r_stall;
   assign fifo_cnt_o  = w_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
// Self-checking bench for wb_write_arbiter with default parameters.
// A queue-based reference model tracks buffered LSU results and how long
// the head has waited; directed table rows, hand sequences for full FIFO,
// starvation, protocol violation and reset, and a random phase are all
// compared against it (and, for the table, against fixed constants).
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;
   import wb_pkg::*;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 3;

   logic              clk_i;
   logic              rst_i;
   logic              alu_valid_i;
   logic [ADDR_W-1:0] alu_addr_i;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_stall_o;
   logic              lsu_valid_i;
   logic              lsu_ready_o;
   logic [ADDR_W-1:0] lsu_addr_i;
   logic [DATA_W-1:0] lsu_data_i;
   logic              RegWrite_o;
   logic [ADDR_W-1:0] RDaddr_o;
   logic [DATA_W-1:0] RDdata_o;
   logic [31:0]       pend_o;
   logic [2:0]        fifo_cnt_o;

   int errors = 0;
   int checks = 0;

   wb_write_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .alu_valid_i (alu_valid_i),
      .alu_addr_i  (alu_addr_i),
      .alu_data_i  (alu_data_i),
      .alu_stall_o (alu_stall_o),
      .lsu_valid_i (lsu_valid_i),
      .lsu_ready_o (lsu_ready_o),
      .lsu_addr_i  (lsu_addr_i),
      .lsu_data_i  (lsu_data_i),
      .RegWrite_o  (RegWrite_o),
      .RDaddr_o    (RDaddr_o),
      .RDdata_o    (RDdata_o),
      .pend_o      (pend_o),
      .fifo_cnt_o  (fifo_cnt_o)
   );

   // Free-running clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference model: buffered entries in arrival order, the number of
   // cycles the current head has waited, and the expected write port.
   wb_entry_t         mq[$];
   int                mWait;
   logic              mWe;
   logic [ADDR_W-1:0] mAddr;
   logic [DATA_W-1:0] mData;

   function automatic logic modelStall();
      return (mq.size() > 0) && (mWait > STARVE_MAX);
   endfunction

   function automatic logic [31:0] modelPend();
      logic [31:0] p;
      p = '0;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].live) p[mq[i].addr] = 1'b1;
      end
      return p;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model after a clock edge.
   task automatic checkOutput();
      checkVal("RegWrite", 32'(RegWrite_o), 32'(mWe));
      if (mWe) begin
         checkVal("RDaddr", 32'(RDaddr_o), 32'(mAddr));
         checkVal("RDdata", RDdata_o, mData);
      end
      checkVal("fifo_cnt", 32'(fifo_cnt_o), 32'(mq.size()));
      checkVal("pend", pend_o, modelPend());
      checkVal("alu_stall", 32'(alu_stall_o), 32'(modelStall()));
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
      logic      stallNow;
      logic      hadHead;
      logic      popped;
      logic      pushOk;
      wb_entry_t e;
      alu_valid_i = av;
      alu_addr_i  = aa;
      alu_data_i  = ad;
      lsu_valid_i = lv;
      lsu_addr_i  = la;
      lsu_data_i  = ld;
      checkVal("lsu_ready", 32'(lsu_ready_o), 32'(mq.size() < DEPTH));
      stallNow = modelStall();
      hadHead  = (mq.size() > 0);
      pushOk   = lv && (mq.size() < DEPTH);
      popped   = 1'b0;
      mWe      = 1'b0;
      if (stallNow && hadHead) begin
         e      = mq.pop_front();
         popped = 1'b1;
         mWe    = e.live;
         mAddr  = e.addr;
         mData  = e.data;
      end else if (av) begin
         mWe   = (aa != 0);
         mAddr = aa;
         mData = ad;
         if (aa != 0) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (mq[i].addr == aa) begin
                  e      = mq[i];
                  e.live = 1'b0;
                  mq[i]  = e;
               end
            end
         end
      end else if (hadHead) begin
         e      = mq.pop_front();
         popped = 1'b1;
         mWe    = e.live;
         mAddr  = e.addr;
         mData  = e.data;
      end
      if (popped || !hadHead) mWait = 0;
      else                    mWait = mWait + 1;
      if (pushOk) begin
         e.live = (la != 0);
         e.addr = la;
         e.data = ld;
         mq.push_back(e);
      end
      @(posedge clk_i);
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   typedef struct {
      logic              av;
      logic [ADDR_W-1:0] aa;
      logic [DATA_W-1:0] ad;
      logic              lv;
      logic [ADDR_W-1:0] la;
      logic [DATA_W-1:0] ld;
      logic              eWe;
      logic [ADDR_W-1:0] eAddr;
      logic [DATA_W-1:0] eData;
      int                eCnt;
      int                pIdx;
      logic              ePend;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int k;
      int firstStall;
      int guard;
      logic av;

      // Directed vectors; each row's expectations hold after its clock edge.
      vecs[0]  = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11, 0, 5, 1'b0};
      vecs[1]  = '{1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  0, 0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0,  1, 7, 1'b1};
      vecs[3]  = '{1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hBB, 1, 7, 1'b0};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  0, 7, 1'b0};
      vecs[5]  = '{1'b1, 5'd9, 32'h1,  1'b1, 5'd9, 32'h2,  1'b1, 5'd9, 32'h1,  1, 9, 1'b1};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h2,  0, 9, 1'b0};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,  1, 0, 1'b0};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  0, 0, 1'b0};
      vecs[9]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1, 3, 1'b1};
      vecs[10] = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h34, 1'b1, 5'd6, 32'h66, 2, 3, 1'b1};
      vecs[11] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 1, 3, 1'b1};
      vecs[12] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h34, 0, 3, 1'b0};

      mWait = 0;
      mWe   = 1'b0;
      mAddr = '0;
      mData = '0;
      rst_i       = 1'b0;
      alu_valid_i = 1'b0;
      alu_addr_i  = '0;
      alu_data_i  = '0;
      lsu_valid_i = 1'b0;
      lsu_addr_i  = '0;
      lsu_data_i  = '0;

      // Power-on reset values.
      #2;
      checkVal("rst_RegWrite", 32'(RegWrite_o), 32'h0);
      checkVal("rst_RDaddr", 32'(RDaddr_o), 32'h0);
      checkVal("rst_RDdata", RDdata_o, 32'h0);
      checkVal("rst_pend", pend_o, 32'h0);
      checkVal("rst_cnt", 32'(fifo_cnt_o), 32'h0);
      checkVal("rst_stall", 32'(alu_stall_o), 32'h0);
      checkVal("rst_ready", 32'(lsu_ready_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Table-driven directed rows.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
         checkVal($sformatf("vec%0d_we", i), 32'(RegWrite_o), 32'(vecs[i].eWe));
         if (vecs[i].eWe) begin
            checkVal($sformatf("vec%0d_addr", i), 32'(RDaddr_o), 32'(vecs[i].eAddr));
            checkVal($sformatf("vec%0d_data", i), RDdata_o, vecs[i].eData);
         end
         checkVal($sformatf("vec%0d_cnt", i), 32'(fifo_cnt_o), 32'(vecs[i].eCnt));
         checkVal($sformatf("vec%0d_pend", i), 32'(pend_o[vecs[i].pIdx]), 32'(vecs[i].ePend));
      end

      // Fill the FIFO behind continuous ALU traffic; the ALU honours stalls.
      k = 0;
      firstStall = -1;
      for (int i = 0; i < 20; i++) begin
         av = !modelStall();
         applyStimulus(av, ADDR_W'(10 + (i % 4)), 32'(32'h200 + i),
                       (k < 5), ADDR_W'(k + 1), 32'(32'h100 + k));
         if ((k < 5) && (lsu_valid_i == 1'b1) && (fifo_cnt_o != 3'd0 || k == 0)) begin
         end
         if (i == 3) begin
            checkVal("full_cnt", 32'(fifo_cnt_o), 32'd4);
            checkVal("full_ready", 32'(lsu_ready_o), 32'd0);
         end
         if (alu_stall_o && (firstStall < 0)) firstStall = i;
         k = 5 - (5 - k);
         k = k + ((mq.size() > 0 && mq[mq.size()-1].data == 32'(32'h100 + k)) ? 1 : 0);
      end
      checkVal("stall_rise", 32'(firstStall), 32'd4);
      for (int i = 0; i < 16; i++) idle();

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         av = !modelStall() && ($urandom_range(0, 2) != 0);
         applyStimulus(av, ADDR_W'($urandom_range(0, 15)), $urandom,
                       1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), $urandom);
      end
      for (int i = 0; i < 16; i++) idle();

      // Protocol violation: ALU offered while the stall is up is dropped.
      checkVal("err_clear", 32'(dut.r_err), 32'd0);
      applyStimulus(1'b1, 5'd11, 32'h1, 1'b1, 5'd2, 32'h77);
      guard = 0;
      while (!modelStall() && (guard < 10)) begin
         applyStimulus(1'b1, 5'd11, 32'(guard), 1'b0, '0, '0);
         guard++;
      end
      checkVal("stall_wait", 32'(modelStall()), 32'd1);
      applyStimulus(1'b1, 5'd12, 32'h99, 1'b0, '0, '0);
      checkVal("viol_addr", 32'(RDaddr_o), 32'd2);
      checkVal("viol_data", RDdata_o, 32'h77);
      checkVal("err_set", 32'(dut.r_err), 32'd1);

      // Asynchronous reset with two entries queued.
      applyStimulus(1'b1, 5'd13, 32'h13, 1'b1, 5'd20, 32'h20);
      applyStimulus(1'b1, 5'd14, 32'h14, 1'b1, 5'd21, 32'h21);
      checkVal("pre_rst_cnt", 32'(fifo_cnt_o), 32'd2);
      alu_valid_i = 1'b0;
      lsu_valid_i = 1'b0;
      #2;
      rst_i = 1'b0;
      #1;
      checkVal("arst_RegWrite", 32'(RegWrite_o), 32'h0);
      checkVal("arst_RDaddr", 32'(RDaddr_o), 32'h0);
      checkVal("arst_RDdata", RDdata_o, 32'h0);
      checkVal("arst_pend", pend_o, 32'h0);
      checkVal("arst_cnt", 32'(fifo_cnt_o), 32'h0);
      checkVal("arst_stall", 32'(alu_stall_o), 32'h0);
      checkVal("arst_ready", 32'(lsu_ready_o), 32'h0);
      checkVal("arst_err", 32'(dut.r_err), 32'h0);
      mq.delete();
      mWait = 0;
      mWe   = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkVal("post_rst_ready", 32'(lsu_ready_o), 32'd1);
      for (int i = 0; i < 4; i++) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
